matrix_pingpong_buffer: RTL and testbench
=========================================

# matrix_pingpong_buffer

Double-buffered N×N block buffer with per-block transpose/pass-through and a valid/ready handshake on both sides. It sits between row-wise 1-D DCT/IDCT stages, turning a row-serial block into column-serial order. Replaces the single-bank transpose buffer in the FDCT/IDCT chain: one block is written while the previous one is read, so back-to-back blocks stream without gaps, and downstream stalls propagate upstream.

## Interface
- `W`, 16: element width in bits, signed two's complement, stored verbatim.
- `N`, 8: block dimension; rows per block and elements per row; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input row valid.
- `in_ready` out 1: buffer can accept a row.
- `in_data` in N×W, packed `[N-1:0][W-1:0]`: input row; element i = column i.
- `in_sob` in 1: first row of block.
- `in_eob` in 1: last row of block.
- `in_sof` in 1: first block of frame; qualified by `in_sob`.
- `in_trps` in 1: 1 = transpose this block, 0 = pass through; sampled with `in_sob`.
- `out_valid` out 1: output row valid.
- `out_ready` in 1: downstream accepts row.
- `out_data` out N×W: output row.
- `out_sob`, `out_eob`, `out_sof` out 1 each: framing of the output row.
- `err_frame` out 1: one-cycle pulse on a framing violation.

## Operation
- Two banks, each N rows × N×W. Per bank: `full` flag, stored `sof`, stored `trps`.
- Write side: `wr_sel` bank, `wr_row` counter 0..N-1. A row is accepted when `in_valid && in_ready`. Accepted row goes to `bank[wr_sel].row[wr_row]`.
- `in_ready = !full[wr_sel]`.
- Accepted row with `in_sob`: latch `in_sof`/`in_trps` into the bank. If `wr_row != 0`, pulse `err_frame`, discard the partial block and write this row as row 0.
- Accepted row at `wr_row == N-1`: set `full[wr_sel]`, toggle `wr_sel`, reset `wr_row` to 0. `err_frame` pulses if `in_eob` is 0 on this row, or if `in_eob` is 1 on any other row. The counter, not `in_eob`, decides block completion.
- Read side: `rd_sel` bank, `rd_row` counter. `out_valid = full[rd_sel]`.
- Output row r: if `trps` then `out_data[i] = bank.row[i][r]` (column r), else `bank.row[r]`.
- `out_sob = (rd_row==0)`, `out_eob = (rd_row==N-1)`, `out_sof = out_sob && bank.sof`. All are gated by `out_valid`; all are 0 otherwise.
- Row transfer on `out_valid && out_ready`: increment `rd_row`. On row N-1, clear `full[rd_sel]`, toggle `rd_sel` and reset `rd_row`.
- Blocks leave in arrival order. No data is dropped except partial blocks restarted by `in_sob`.

## Timing
- Reset values: `wr_sel=rd_sel=0`, counters 0, both `full=0`. Outputs: `in_ready=1`, `out_valid=0`, all framing flags 0, `err_frame=0`, `out_data` all zeros.
- Latency: the last input row is accepted at edge k; `out_valid` rises after edge k, so row 0 of that block is presented in cycle k+1.
- Steady state with `out_ready=1`: one row in and one row out per cycle, with no bubbles.
- Stall: while `out_valid && !out_ready`, `out_data` and the framing flags hold stable.
- Both banks full: `in_ready=0` until the read side finishes a block.
- Simultaneous events:
  - A read-side clear and a write-side set of `full` can occur in the same cycle on different banks; both take effect.
  - When the read side frees the bank that `wr_sel` points to, `in_ready` rises the following cycle (registered `full`). There is no combinational path from `out_ready` to `in_ready`.
- `rst_n` asserted mid-block: all state clears immediately and partial and buffered blocks are lost. The first row after release must carry `in_sob`; if it does not, it is written as row 0 without an error.
- Storage needs no reset; only control registers and `out_data` gating do.

## Structure
- Package `matrix_buf_pkg`: `row_t` (`logic signed [N-1:0][W-1:0]`) made generic through module-local typedefs, default `N`/`W` constants, and the `ctrl_t` struct {sof, trps}.
- Sub-module `matrix_bank`: one N×N storage with row write port and row-or-column read mux selected by `trps`; instantiated twice.
- Top module holds the counters, the full flags, the handshakes and `err_frame`.

## Test plan
- Single block, `trps=1`, N=8, `in_data[c]` of row r = 8r+c → output row r element i = 8i+r; `out_sob` on row 0 only, `out_eob` on row 7 only, first row out one cycle after the eob edge.
- Same block with `trps=0`, `sof=1` → output equals input row-for-row; `out_sof=1` on row 0.
- 4 back-to-back blocks, `out_ready=1` → `in_ready` stays 1, output is gapless, and blocks come out in order with the correct per-block `trps`.
- `out_ready=0` for 20 cycles while 3 blocks are offered → `in_ready` drops after the 2nd block completes and the `out_data` hold is stable. On release all blocks arrive intact.
- `in_sob` at `wr_row=5` → `err_frame` pulses once, the partial block is discarded, and the new block outputs correctly. `in_eob` on row 3 → `err_frame` pulses and the block still completes at row 7.
- Async reset asserted with 1.5 blocks buffered → next cycle `out_valid=0`, `in_ready=1`; the following block is processed normally.

Source files
------------

// File: rtl/matrix_pingpong_buffer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// matrix_buf_pkg : shared types and defaults for the ping-pong block buffer
// Revision 1.0
// ------------------------------------------------------------------------
package matrix_buf_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 16;

  // Default-size row; modules re-declare it locally for their own N/W.
  typedef logic signed [N_DEF-1:0][W_DEF-1:0] row_t;

  typedef struct packed {
    logic sof;
    logic trps;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/matrix_pingpong_buffer_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// matrix_pingpong_buffer_if : row-stream handshakes on both buffer sides
// Revision 1.0
// ------------------------------------------------------------------------
interface matrix_pingpong_buffer_if
  import matrix_buf_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [N-1:0][W-1:0]   in_data;
  logic                         in_sob;
  logic                         in_eob;
  logic                         in_sof;
  logic                         in_trps;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [N-1:0][W-1:0]   out_data;
  logic                         out_sob;
  logic                         out_eob;
  logic                         out_sof;

  logic                         err_frame;

  modport slave (
    input  in_valid, in_data, in_sob, in_eob, in_sof, in_trps, out_ready,
    output in_ready, out_valid, out_data, out_sob, out_eob, out_sof, err_frame
  );

  modport master (
    output in_valid, in_data, in_sob, in_eob, in_sof, in_trps, out_ready,
    input  in_ready, out_valid, out_data, out_sob, out_eob, out_sof, err_frame
  );

endinterface
`default_nettype wire

// File: rtl/matrix_pingpong_buffer_bank.sv
`default_nettype none
// ------------------------------------------------------------------------
// matrix_bank : one NxN storage bank, row write port, row-or-column read
// Revision 1.0
// ------------------------------------------------------------------------
module matrix_bank
  import matrix_buf_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  wire logic                       clk,
  input  wire logic                       wr_en,
  input  wire logic [$clog2(N)-1:0]       wr_row,
  input  wire logic signed [N-1:0][W-1:0] wr_data,
  input  wire logic [$clog2(N)-1:0]       rd_row,
  input  wire logic                       trps,
  output logic signed [N-1:0][W-1:0]      rd_data
);

  typedef logic signed [N-1:0][W-1:0] row_t;

  row_t r_mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_row] <= wr_data;
    end
  end

  // Transposed read picks element rd_row out of every stored row (a column).
  for (genvar i = 0; i < N; i++) begin : g_col
    assign rd_data[i] = trps ? r_mem[i][rd_row] : r_mem[rd_row][i];
  end

endmodule
`default_nettype wire

// File: rtl/matrix_pingpong_buffer.sv
`default_nettype none
// ------------------------------------------------------------------------
// matrix_pingpong_buffer : double-buffered NxN block transpose/pass buffer
// Revision 1.0
// ------------------------------------------------------------------------
module matrix_pingpong_buffer
  import matrix_buf_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  matrix_pingpong_buffer_if.slave    bus
);

  localparam int             LG   = $clog2(N);
  localparam logic [LG-1:0]  LAST = LG'(N - 1);

  typedef logic signed [N-1:0][W-1:0] row_t;

  logic            r_wr_sel;
  logic            r_rd_sel;
  logic [LG-1:0]   r_wr_row;
  logic [LG-1:0]   r_rd_row;
  logic [1:0]      r_full;
  ctrl_t           r_ctrl [2];
  logic            r_err;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_wr_fire;
  logic            w_rd_fire;
  logic [LG-1:0]   w_wr_idx;
  logic            w_wr_last;
  logic            w_rd_last;
  logic            w_err;
  logic [1:0]      w_full_set;
  logic [1:0]      w_full_clr;
  row_t            w_bank_rd [2];

  always_comb begin
    w_in_ready  = !r_full[r_wr_sel];
    w_out_valid = r_full[r_rd_sel];
    w_wr_fire   = bus.in_valid && w_in_ready;
    w_rd_fire   = w_out_valid && bus.out_ready;
    // A start-of-block row always lands in row 0, restarting any partial block.
    w_wr_idx    = bus.in_sob ? '0 : r_wr_row;
    w_wr_last   = (w_wr_idx == LAST);
    w_rd_last   = (r_rd_row == LAST);
    w_err       = w_wr_fire &&
                  ((bus.in_sob && (r_wr_row != '0)) || (w_wr_last != bus.in_eob));
    w_full_set  = (w_wr_fire && w_wr_last) ? (2'b01 << r_wr_sel) : 2'b00;
    w_full_clr  = (w_rd_fire && w_rd_last) ? (2'b01 << r_rd_sel) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_wr_row  <= '0;
      r_rd_row  <= '0;
      r_full    <= 2'b00;
      r_ctrl[0] <= '0;
      r_ctrl[1] <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err  <= w_err;
      // Set and clear never target the same bank, so both apply together.
      r_full <= (r_full | w_full_set) & ~w_full_clr;

      if (w_wr_fire) begin
        if (bus.in_sob) begin
          r_ctrl[r_wr_sel].sof  <= bus.in_sof;
          r_ctrl[r_wr_sel].trps <= bus.in_trps;
        end
        if (w_wr_last) begin
          r_wr_sel <= !r_wr_sel;
          r_wr_row <= '0;
        end else begin
          r_wr_row <= w_wr_idx + LG'(1);
        end
      end

      if (w_rd_fire) begin
        if (w_rd_last) begin
          r_rd_sel <= !r_rd_sel;
          r_rd_row <= '0;
        end else begin
          r_rd_row <= r_rd_row + LG'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_bank #(
      .N (N),
      .W (W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (w_wr_fire && (r_wr_sel == 1'(b))),
      .wr_row  (w_wr_idx),
      .wr_data (bus.in_data),
      .rd_row  (r_rd_row),
      .trps    (r_ctrl[b].trps),
      .rd_data (w_bank_rd[b])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_bank_rd[r_rd_sel] : '0;
  assign bus.out_sob   = w_out_valid && (r_rd_row == '0);
  assign bus.out_eob   = w_out_valid && w_rd_last;
  assign bus.out_sof   = w_out_valid && (r_rd_row == '0) && r_ctrl[r_rd_sel].sof;
  assign bus.err_frame = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_pingpong_buffer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_matrix_pingpong_buffer : directed bench with a block-queue reference model
// Revision 1.0
// ------------------------------------------------------------------------
module tb_matrix_pingpong_buffer;
  import matrix_buf_pkg::*;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int RW = N * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_pingpong_buffer_if #(.N(N), .W(W)) bus ();

  matrix_pingpong_buffer #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk    = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int wait_cyc = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: completed blocks are kept already arranged in output order.
  logic [RW-1:0] q_rows [$];
  bit            q_sof  [$];
  int            m_rd  = 0;
  int            pcnt  = 0;
  bit            ptrps = 0;
  bit            psof  = 0;
  bit            exp_err = 0;
  logic [W-1:0]  part [N][N];

  always @(posedge clk or negedge rst_n) begin : p_model
    int            nblk;
    bit            acc;
    bit            rd;
    bit            e;
    logic [RW-1:0] rowv;
    if (!rst_n) begin
      q_rows.delete();
      q_sof.delete();
      m_rd    = 0;
      pcnt    = 0;
      ptrps   = 0;
      psof    = 0;
      exp_err = 0;
    end else begin
      nblk = q_sof.size();
      acc  = bus.in_valid && (nblk < 2);
      rd   = (nblk > 0) && bus.out_ready;
      e    = 0;
      if (rd) begin
        m_rd++;
        if (m_rd == N) begin
          repeat (N) void'(q_rows.pop_front());
          void'(q_sof.pop_front());
          m_rd = 0;
        end
      end
      if (acc) begin
        if (bus.in_sob) begin
          if (pcnt != 0) e = 1;
          pcnt  = 0;
          ptrps = bus.in_trps;
          psof  = bus.in_sof;
        end
        if ((pcnt == N - 1) != bus.in_eob) e = 1;
        for (int c = 0; c < N; c++) part[pcnt][c] = bus.in_data[c];
        pcnt++;
        if (pcnt == N) begin
          for (int r = 0; r < N; r++) begin
            for (int i = 0; i < N; i++)
              rowv[i*W +: W] = ptrps ? part[i][r] : part[r][i];
            q_rows.push_back(rowv);
          end
          q_sof.push_back(psof);
          pcnt = 0;
        end
      end
      exp_err = e;
    end
  end

  always @(negedge clk) begin : p_compare
    int            nb;
    logic [RW-1:0] ed;
    nb = q_sof.size();
    ed = '0;
    if (nb > 0) ed = q_rows[m_rd];
    chk("in_ready",  bus.in_ready,  nb < 2);
    chk("out_valid", bus.out_valid, nb > 0);
    chk("out_data",  bus.out_data,  ed);
    chk("out_sob",   bus.out_sob,   (nb > 0) && (m_rd == 0));
    chk("out_eob",   bus.out_eob,   (nb > 0) && (m_rd == N - 1));
    chk("out_sof",   bus.out_sof,   (nb > 0) && (m_rd == 0) && q_sof[0]);
    chk("err_frame", bus.err_frame, exp_err);
    if (bus.err_frame) err_seen++;
  end

  task automatic send_row(input int base, input int r, input bit sob, input bit eob,
                          input bit sof, input bit trps);
    int t;
    bit rdy;
    for (int c = 0; c < N; c++) bus.in_data[c] = W'(base + N * r + c);
    bus.in_sob   = sob;
    bus.in_eob   = eob;
    bus.in_sof   = sof;
    bus.in_trps  = trps;
    bus.in_valid = 1'b1;
    t = 0;
    do begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 200);
    wait_cyc += t;
    if (!rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: row %0d of base %0d not accepted in %0d cycles", r, base, t);
    end
  endtask

  task automatic send_block(input int base, input bit trps, input bit sof, input int bad_eob);
    for (int r = 0; r < N; r++)
      send_row(base, r, r == 0, (r == N - 1) || (r == bad_eob), sof, trps);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : p_stim
    int t0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sob    = 1'b0;
    bus.in_eob    = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_trps   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready",  bus.in_ready,  1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data",  bus.out_data,  0);

    // Single transposed block: row r element i must be 8i+r.
    send_block(0, 1'b1, 1'b0, -1);
    chk("t1_first_row_valid", bus.out_valid,   1);
    chk("t1_row0_elem3",      bus.out_data[3], 24);
    chk("t1_row0_sob",        bus.out_sob,     1);
    @(posedge clk);
    #1;
    chk("t1_row1_elem2",      bus.out_data[2], 17);
    idle(12);

    // Pass-through with sof.
    send_block(0, 1'b0, 1'b1, -1);
    chk("t2_row0_sof",   bus.out_sof,     1);
    chk("t2_row0_elem5", bus.out_data[5], 5);
    idle(12);

    // Back-to-back blocks with alternating transpose.
    t0 = wait_cyc;
    for (int b = 0; b < 4; b++) send_block(100 * (b + 1), bit'(b % 2), b == 0, -1);
    chk("t3_no_backpressure", wait_cyc - t0, 4 * N);
    idle(20);

    // Downstream stall while three blocks are offered.
    bus.out_ready = 1'b0;
    fork
      begin
        send_block(1000, 1'b1, 1'b0, -1);
        send_block(2000, 1'b0, 1'b0, -1);
        send_block(3000, 1'b1, 1'b0, -1);
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    chk("t4_in_ready_low",  bus.in_ready,    0);
    chk("t4_held_valid",    bus.out_valid,   1);
    chk("t4_held_elem0",    bus.out_data[0], 1000);
    chk("t4_held_elem1",    bus.out_data[1], 1008);
    bus.out_ready = 1'b1;
    wait fork;
    idle(30);

    // Restart by sob at row 5, then an early eob on row 3.
    t0 = err_seen;
    for (int r = 0; r < 5; r++) send_row(4000, r, r == 0, 1'b0, 1'b0, 1'b1);
    send_block(5000, 1'b1, 1'b0, -1);
    idle(14);
    chk("t5_sob_restart_err", err_seen - t0, 1);
    t0 = err_seen;
    send_block(6000, 1'b0, 1'b0, 3);
    idle(14);
    chk("t5_eob_early_err", err_seen - t0, 1);

    // Asynchronous reset with 1.5 blocks buffered.
    bus.out_ready = 1'b0;
    send_block(7000, 1'b1, 1'b0, -1);
    for (int r = 0; r < 4; r++) send_row(8000, r, r == 0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_reset_out_valid", bus.out_valid, 0);
    chk("t6_reset_in_ready",  bus.in_ready,  1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_block(9000, 1'b1, 1'b1, -1);
    chk("t6_after_reset_sof",   bus.out_sof,     1);
    chk("t6_after_reset_elem1", bus.out_data[1], 9008);
    idle(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
